tick_period_monitor: RTL and testbench

//  Receive-side checker for the periodic single-cycle carry tick from the free-running stutter counter.

---
 rtl/tick_mon_pkg.sv | 17 +
 rtl/tick_interval_counter.sv | 42 ++++
 rtl/tick_period_monitor.sv | 135 +++++++++++++
 tb/tb_tick_period_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_mon_pkg.sv
// Shared types and helpers for the tick period monitor: FSM state encoding and good-window bounds.
package tick_mon_pkg;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} tick_mon_state_t;

   localparam int ERR_CNT_W = 8;
   localparam int RUN_W     = 8;

   function automatic int win_lo(input int exp_period, input int tol);
      return exp_period - tol;
   endfunction

   function automatic int win_hi(input int exp_period, input int tol);
      return exp_period + tol;
   endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// Saturating cycle counter between ticks; presents the interval of the current cycle and flags a
// one-shot timeout (which marks the interval stale until the next tick re-references it).
module tick_interval_counter #(
   parameter int CNT_W       = 17,
   parameter int TIMEOUT_VAL = 65539
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             arm,
   output logic [CNT_W-1:0] interval,
   output logic             timeout,
   output logic             stale
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_VAL);

   logic [CNT_W-1:0] cnt;

   // Interval saturates with the counter instead of wrapping back to zero.
   assign interval = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
   assign timeout  = arm && !tick_in && !stale && (interval == TO_VAL);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         stale <= 1'b0;
      end else begin
         if (tick_in)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);

         if (tick_in)
            stale <= 1'b0;
         else if (timeout)
            stale <= 1'b1;
      end
   end

endmodule

// File: rtl/tick_period_monitor.sv
// Qualifies a periodic tick: lock FSM, measured period, error pulse/count; outputs lag the tick by one cycle.
// Define TICK_MON_HIST_EN to build min/max tracking of judged intervals (otherwise tied to 0).
module tick_period_monitor
   import tick_mon_pkg::*;
#(
   parameter int CNT_W      = 17,
   parameter int EXP_PERIOD = 65536,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_in,
   output logic [CNT_W-1:0]     period_out,
   output logic                 period_valid,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [CNT_W-1:0]     period_min,
   output logic [CNT_W-1:0]     period_max
);

   localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(win_lo(EXP_PERIOD, TOL));
   localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(win_hi(EXP_PERIOD, TOL));
   localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_COUNT);
   localparam logic [RUN_W-1:0] LOSS_N = RUN_W'(LOSS_COUNT);

   tick_mon_state_t  state, state_nxt;
   logic [RUN_W-1:0] good_run, good_run_nxt, bad_run, bad_run_nxt;
   logic [CNT_W-1:0] interval;
   logic             timeout, stale;
   logic             report, judge, good, good_evt, bad_evt;

   tick_interval_counter #(
      .CNT_W       (CNT_W),
      .TIMEOUT_VAL (EXP_PERIOD + TOL + 1)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .tick_in  (tick_in),
      .arm      (state != IDLE),
      .interval (interval),
      .timeout  (timeout),
      .stale    (stale)
   );

   // A tick after a timeout is reported but only re-references the counter.
   assign report   = tick_in && (state != IDLE);
   assign judge    = report && !stale;
   assign good     = (interval >= WIN_LO) && (interval <= WIN_HI);
   assign good_evt = judge && good;
   assign bad_evt  = (judge && !good) || timeout;
   assign locked   = (state == LOCKED);

   always_comb begin
      state_nxt    = state;
      good_run_nxt = good_run;
      bad_run_nxt  = bad_run;
      case (state)
         IDLE: begin
            if (tick_in) begin
               state_nxt    = ACQUIRE;
               good_run_nxt = '0;
            end
         end
         ACQUIRE: begin
            if (good_evt) begin
               good_run_nxt = good_run + RUN_W'(1);
               if (good_run_nxt == LOCK_N) begin
                  state_nxt   = LOCKED;
                  bad_run_nxt = '0;
               end
            end else if (bad_evt) begin
               good_run_nxt = '0;
            end
         end
         LOCKED: begin
            if (good_evt) begin
               bad_run_nxt = '0;
            end else if (bad_evt) begin
               bad_run_nxt = bad_run + RUN_W'(1);
               if (bad_run_nxt == LOSS_N) begin
                  state_nxt    = ACQUIRE;
                  good_run_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         good_run     <= '0;
         bad_run      <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
         err_pulse    <= 1'b0;
         err_count    <= '0;
      end else begin
         state        <= state_nxt;
         good_run     <= good_run_nxt;
         bad_run      <= bad_run_nxt;
         period_valid <= report;
         err_pulse    <= bad_evt;
         if (report)
            period_out <= interval;
         if (bad_evt && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
      end
   end

`ifdef TICK_MON_HIST_EN
   logic [CNT_W-1:0] min_q, max_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         min_q <= '1;
         max_q <= '0;
      end else if (judge) begin
         if (interval < min_q) min_q <= interval;
         if (interval > max_q) max_q <= interval;
      end
   end

   assign period_min = min_q;
   assign period_max = max_q;
`else
   assign period_min = '0;
   assign period_max = '0;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// Bench for tick_period_monitor: directed vector table, hand sequences and random intervals vs a reference model.
module tb_tick_period_monitor;

   localparam int CNT_W = 8;
   localparam int EXP   = 16;
   localparam int TOL   = 1;
   localparam int LOCKN = 4;
   localparam int LOSSN = 2;
   localparam int SAT   = 255;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             tick_in = 1'b0;
   logic [CNT_W-1:0] period_out, period_min, period_max;
   logic             period_valid, locked, err_pulse;
   logic [7:0]       err_count;

   always #5 clk = ~clk;

   tick_period_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LOCKN), .LOSS_COUNT(LOSSN)
   ) dut (
      .clk(clk), .reset(reset), .tick_in(tick_in),
      .period_out(period_out), .period_valid(period_valid), .locked(locked),
      .err_pulse(err_pulse), .err_count(err_count),
      .period_min(period_min), .period_max(period_max)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: age = cycles since the reference tick; mode 0/1/2 = idle/acquiring/locked.
   int m_age, m_mode, m_good, m_bad, m_errc, m_period, m_min, m_max;
   bit m_stale, m_pv, m_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_age = 0; m_mode = 0; m_good = 0; m_bad = 0; m_errc = 0;
      m_period = 0; m_min = SAT; m_max = 0;
      m_stale = 0; m_pv = 0; m_err = 0;
   endtask

   task automatic model_step(input bit t);
      int  iv;
      bit  bad, good;
      iv = m_age + 1;
      m_pv = 0; m_err = 0; bad = 0; good = 0;
      if (t) begin
         if (m_mode == 0) begin
            m_mode = 1;
            m_good = 0;
         end else begin
            m_pv = 1;
            m_period = (iv > SAT) ? SAT : iv;
            if (m_stale) begin
               m_stale = 0;
            end else begin
               if (iv >= EXP - TOL && iv <= EXP + TOL) good = 1;
               else bad = 1;
               if (m_period < m_min) m_min = m_period;
               if (m_period > m_max) m_max = m_period;
            end
         end
         m_age = 0;
      end else begin
         if (m_mode != 0 && !m_stale && iv == EXP + TOL + 1) begin
            bad = 1;
            m_stale = 1;
         end
         m_age++;
      end
      if (bad) begin
         m_err = 1;
         if (m_errc < SAT) m_errc++;
         if (m_mode == 1) m_good = 0;
         else begin
            m_bad++;
            if (m_bad >= LOSSN) begin m_mode = 1; m_good = 0; end
         end
      end
      if (good) begin
         if (m_mode == 1) begin
            m_good++;
            if (m_good >= LOCKN) begin m_mode = 2; m_bad = 0; end
         end else begin
            m_bad = 0;
         end
      end
   endtask

   task automatic step(input bit rst, input bit t);
      reset = rst;
      tick_in = t;
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else model_step(t);
      chk("period_out", int'(period_out), m_period);
      chk("period_valid", int'(period_valid), int'(m_pv));
      chk("err_pulse", int'(err_pulse), int'(m_err));
      chk("err_count", int'(err_count), m_errc);
      chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
`ifdef TICK_MON_HIST_EN
      chk("period_min", int'(period_min), m_min);
      chk("period_max", int'(period_max), m_max);
`else
      chk("period_min", int'(period_min), 0);
      chk("period_max", int'(period_max), 0);
`endif
   endtask

   task automatic gap_tick(input int gap);
      repeat (gap - 1) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
   endtask

   typedef struct {
      int gap;
      int pv;
      int err;
      int lk;
      int period;
      int errc;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int n_err, at_err, r, gap;

      tbl.push_back('{5,  0, 0, 0, 0,  0});
      tbl.push_back('{16, 1, 0, 0, 16, 0});
      tbl.push_back('{16, 1, 0, 0, 16, 0});
      tbl.push_back('{16, 1, 0, 0, 16, 0});
      tbl.push_back('{16, 1, 0, 1, 16, 0});
      tbl.push_back('{17, 1, 0, 1, 17, 0});
      tbl.push_back('{15, 1, 0, 1, 15, 0});
      tbl.push_back('{16, 1, 0, 1, 16, 0});
      tbl.push_back('{18, 1, 1, 1, 18, 1});
      tbl.push_back('{18, 1, 1, 0, 18, 2});
      tbl.push_back('{16, 1, 0, 0, 16, 2});
      tbl.push_back('{16, 1, 0, 0, 16, 2});
      tbl.push_back('{16, 1, 0, 0, 16, 2});
      tbl.push_back('{16, 1, 0, 1, 16, 2});

      model_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("rst_period_out", int'(period_out), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_count", int'(err_count), 0);

      // Lock acquisition, in-window jitter, loss of lock and relock.
      for (int i = 0; i < tbl.size(); i++) begin
         gap_tick(tbl[i].gap);
         chk($sformatf("t%0d_pv", i), int'(period_valid), tbl[i].pv);
         chk($sformatf("t%0d_err", i), int'(err_pulse), tbl[i].err);
         chk($sformatf("t%0d_locked", i), int'(locked), tbl[i].lk);
         chk($sformatf("t%0d_period", i), int'(period_out), tbl[i].period);
         chk($sformatf("t%0d_errc", i), int'(err_count), tbl[i].errc);
      end

      // Ticks stop while locked: exactly one timeout, then an unjudged stale tick.
      n_err = 0; at_err = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1'b0, 1'b0);
         if (err_pulse) begin n_err++; at_err = k; end
      end
      chk("timeout_count", n_err, 1);
      chk("timeout_cycle", at_err, 18);
      chk("timeout_locked", int'(locked), 1);
      step(1'b0, 1'b1);
      chk("stale_pv", int'(period_valid), 1);
      chk("stale_err", int'(err_pulse), 0);
      chk("stale_locked", int'(locked), 1);
      chk("stale_period", int'(period_out), 41);
      chk("stale_errc", int'(err_count), 3);
      gap_tick(16);

      // One-cycle reset mid-interval.
      repeat (7) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("mid_rst_period", int'(period_out), 0);
      chk("mid_rst_locked", int'(locked), 0);
      chk("mid_rst_errc", int'(err_count), 0);
      chk("mid_rst_pv", int'(period_valid), 0);
      gap_tick(16);
      chk("post_rst_pv", int'(period_valid), 0);
      chk("post_rst_locked", int'(locked), 0);

      // Error counter saturation, with a mix of window edges for min/max.
      gap_tick(15);
      gap_tick(17);
      gap_tick(16);
      for (int i = 0; i < 300; i++) gap_tick(18);
      chk("sat_errc", int'(err_count), 255);
      chk("sat_err_pulse", int'(err_pulse), 1);
`ifdef TICK_MON_HIST_EN
      chk("hist_min", int'(period_min), 15);
      chk("hist_max", int'(period_max), 18);
`endif

      // Random intervals, including back-to-back ticks, long gaps, counter saturation and resets.
      step(1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            step(1'b1, 1'b0);
         end else begin
            if (r < 60)      gap = $urandom_range(15, 17);
            else if (r < 80) gap = $urandom_range(1, 20);
            else if (r < 95) gap = $urandom_range(21, 60);
            else             gap = $urandom_range(250, 300);
            gap_tick(gap);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
